// File: rtl/sram22_ctrl_pkg.sv
// Shared defaults and types for the SRAM22 port arbiter.
// The scrub state type is only used when SRAM22_ARB_SCRUB_EN is defined.
package sram22_ctrl_pkg;

    localparam int ADDR_WIDTH_DEF  = 8;
    localparam int DATA_WIDTH_DEF  = 64;
    localparam int WMASK_WIDTH_DEF = 8;
    localparam int LANE_WIDTH_DEF  = DATA_WIDTH_DEF / WMASK_WIDTH_DEF;

    typedef enum logic {
        SCRUB = 1'b0,
        RUN   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sram22_port_arbiter_if.sv
// Requester-side bundle of the SRAM22 port arbiter.
// Per-requester fields are packed side by side, requester i at [i*W +: W].
interface sram22_port_arbiter_if
    import sram22_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int WMASK_WIDTH = WMASK_WIDTH_DEF
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ*WMASK_WIDTH-1:0] req_wmask;
    logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [NUM_REQ-1:0]             rsp_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_rdata;

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/sram22_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner.
module sram22_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic [NUM_REQ-1:0] eligible,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] ptr_q;
    int               cand;

    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ptr_q <= '0;
        end else if (grant_valid) begin
            ptr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/sram22_port_arbiter.sv
// Shares one single-port SRAM22 macro among NUM_REQ requesters with per-requester read buffers.
// Define SRAM22_ARB_SCRUB_EN to zero the whole macro after every reset before accepting requests.
module sram22_port_arbiter
    import sram22_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int WMASK_WIDTH = WMASK_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rstb,
    sram22_port_arbiter_if.slave   bus,
    output logic                   sram_ce,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout,
    output logic                   init_done
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic                          run;
    logic                          scrubbing;
    logic [ADDR_WIDTH-1:0]         scrub_addr;
    logic [NUM_REQ-1:0]            pending_q;
    logic [NUM_REQ-1:0]            rsp_valid_q;
    logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data_q;
    logic [NUM_REQ-1:0]            eligible;
    logic [NUM_REQ-1:0]            grant;
    logic [IDX_W-1:0]              grant_idx;
    logic                          grant_valid;

`ifdef SRAM22_ARB_SCRUB_EN
    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] scrub_addr_d;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= SCRUB;
            scrub_addr <= '0;
        end else begin
            state_q    <= state_d;
            scrub_addr <= scrub_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        scrub_addr_d = scrub_addr;
        case (state_q)
            SCRUB: begin
                scrub_addr_d = scrub_addr + ADDR_WIDTH'(1);
                if (scrub_addr == '1) state_d = RUN;
            end
            RUN: ;
        endcase
    end

    assign run       = (state_q == RUN);
    assign scrubbing = (state_q == SCRUB);
`else
    // Without scrub the block is live exactly while reset is released.
    assign run        = rstb;
    assign scrubbing  = 1'b0;
    assign scrub_addr = '0;
`endif

    // A read needs a free response slot; writes produce no response and are always eligible.
    assign eligible = {NUM_REQ{run}} & bus.req_valid & (bus.req_we | ~(rsp_valid_q | pending_q));

    sram22_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk         (clk),
        .rstb        (rstb),
        .eligible    (eligible),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_data_q;
    assign init_done     = run;

    // NOTE: the response buffers are a few flops, not a RAM, so they are reset along with their valid bits.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pending_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            pending_q <= grant & ~bus.req_we;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pending_q[i]) begin
                    rsp_valid_q[i]                          <= 1'b1;
                    rsp_data_q[i*DATA_WIDTH +: DATA_WIDTH]  <= sram_dout;
                end else if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
                    rsp_valid_q[i]                          <= 1'b0;
                    rsp_data_q[i*DATA_WIDTH +: DATA_WIDTH]  <= '0;
                end
            end
        end
    end

    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        if (scrubbing) begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_wmask = '1;
            sram_addr  = scrub_addr;
        end else if (grant_valid) begin
            sram_ce    = 1'b1;
            sram_we    = bus.req_we[grant_idx];
            sram_wmask = bus.req_wmask[int'(grant_idx)*WMASK_WIDTH +: WMASK_WIDTH];
            sram_addr  = bus.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            sram_din   = bus.req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_sram22_port_arbiter.sv
// Bench for sram22_port_arbiter: cycle vector table plus reset/scrub sequences against a 256x64 macro model.
// Build with SRAM22_ARB_SCRUB_EN defined to exercise the scrub variant.
module tb_sram22_port_arbiter;
    import sram22_ctrl_pkg::*;

    localparam logic [63:0] D0   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] DM   = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] A5   = 64'hA5A5_A5A5_A5A5_A5A5;
`ifdef SRAM22_ARB_SCRUB_EN
    localparam int          EXP_INIT = 256;
    localparam logic [7:0]  RST_ADDR = 8'hFF;
    localparam logic [63:0] RST_DATA = 64'h0;
`else
    localparam int          EXP_INIT = 0;
    localparam logic [7:0]  RST_ADDR = 8'h10;
    localparam logic [63:0] RST_DATA = D0;
`endif

    logic        clk;
    logic        rstb;
    logic        sram_ce, sram_we, init_done;
    logic [7:0]  sram_wmask, sram_addr;
    logic [63:0] sram_din, sram_dout;

    sram22_port_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(64), .WMASK_WIDTH(8)) bus ();

    sram22_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(64), .WMASK_WIDTH(8)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .bus        (bus),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout),
        .init_done  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model; preloaded with a non-zero pattern so scrubbing is observable.
    logic [63:0] mem [256];
    logic [63:0] word;
    initial for (int i = 0; i < 256; i++) mem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                word = mem[sram_addr];
                for (int l = 0; l < 8; l++)
                    if (sram_wmask[l]) word[l*LANE_WIDTH_DEF +: LANE_WIDTH_DEF] = sram_din[l*LANE_WIDTH_DEF +: LANE_WIDTH_DEF];
                mem[sram_addr] = word;
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [7:0]  m0;
        logic [7:0]  m1;
        logic [63:0] w0;
        logic [63:0] w1;
        logic [1:0]  rrdy;
        logic [1:0]  e_rdy;
        logic        e_ce;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [7:0]  e_wm;
        logic [63:0] e_din;
        logic [1:0]  e_rv;
        logic [63:0] e_rd0;
        logic [63:0] e_rd1;
    } vec_t;

    localparam int NV = 29;
    vec_t vt [NV];
    vec_t tmp;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic vec_t idle(input logic [1:0] rrdy, input logic [1:0] rv, input logic [63:0] rd0, input logic [63:0] rd1);
        vec_t v;
        v = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 64'h0, 64'h0, rrdy,
              2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0, rv, rd0, rd1};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.req_valid = v.valid;
        bus.req_we    = v.we;
        bus.req_addr  = {v.a1, v.a0};
        bus.req_wmask = {v.m1, v.m0};
        bus.req_wdata = {v.w1, v.w0};
        bus.rsp_ready = v.rrdy;
    endtask

    task automatic compare(input int i, input vec_t v);
        check($sformatf("v%0d req_ready", i), 64'(bus.req_ready), 64'(v.e_rdy));
        check($sformatf("v%0d sram_ce", i), 64'(sram_ce), 64'(v.e_ce));
        check($sformatf("v%0d sram_we", i), 64'(sram_we), 64'(v.e_we));
        check($sformatf("v%0d sram_addr", i), 64'(sram_addr), 64'(v.e_addr));
        check($sformatf("v%0d sram_wmask", i), 64'(sram_wmask), 64'(v.e_wm));
        check($sformatf("v%0d sram_din", i), sram_din, v.e_din);
        check($sformatf("v%0d rsp_valid", i), 64'(bus.rsp_valid), 64'(v.e_rv));
        if (v.e_rv[0]) check($sformatf("v%0d rsp_rdata0", i), bus.rsp_rdata[63:0], v.e_rd0);
        if (v.e_rv[1]) check($sformatf("v%0d rsp_rdata1", i), bus.rsp_rdata[127:64], v.e_rd1);
    endtask

    task automatic wait_init(input string tag);
        int cnt;
        cnt = 0;
        while (init_done !== 1'b1 && cnt < 1000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, " init_done"}, 64'(init_done), 64'd1);
        check({tag, " init latency"}, 64'(cnt), 64'(EXP_INIT));
    endtask

    initial begin
        // valid, we, a0, a1, m0, m1, w0, w1, rrdy | rdy, ce, we, addr, wmask, din, rv, rd0, rd1
        vt[0]  = idle(2'b00, 2'b00, 64'h0, 64'h0);
        vt[1]  = '{2'b01, 2'b01, 8'h10, 8'h00, 8'hFF, 8'h00, D0, 64'h0, 2'b00,  2'b01, 1'b1, 1'b1, 8'h10, 8'hFF, D0, 2'b00, 64'h0, 64'h0};
        vt[2]  = '{2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 64'h0, 64'h0, 2'b00,  2'b01, 1'b1, 1'b0, 8'h10, 8'h00, 64'h0, 2'b00, 64'h0, 64'h0};
        vt[3]  = idle(2'b00, 2'b00, 64'h0, 64'h0);
        vt[4]  = idle(2'b00, 2'b01, D0, 64'h0);
        vt[5]  = idle(2'b01, 2'b01, D0, 64'h0);
        vt[6]  = idle(2'b00, 2'b00, 64'h0, 64'h0);
        vt[7]  = '{2'b10, 2'b10, 8'h00, 8'h20, 8'h00, 8'hFF, 64'h0, ONES, 2'b00,  2'b10, 1'b1, 1'b1, 8'h20, 8'hFF, ONES, 2'b00, 64'h0, 64'h0};
        vt[8]  = '{2'b10, 2'b10, 8'h00, 8'h20, 8'h00, 8'h01, 64'h0, 64'h0, 2'b00,  2'b10, 1'b1, 1'b1, 8'h20, 8'h01, 64'h0, 2'b00, 64'h0, 64'h0};
        vt[9]  = '{2'b10, 2'b00, 8'h00, 8'h20, 8'h00, 8'h00, 64'h0, 64'h0, 2'b00,  2'b10, 1'b1, 1'b0, 8'h20, 8'h00, 64'h0, 2'b00, 64'h0, 64'h0};
        vt[10] = idle(2'b00, 2'b00, 64'h0, 64'h0);
        vt[11] = idle(2'b00, 2'b10, 64'h0, DM);
        // req1 holds a buffered response and asks again; req0 keeps getting served
        vt[12] = '{2'b11, 2'b00, 8'h20, 8'h10, 8'h00, 8'h00, 64'h0, 64'h0, 2'b00,  2'b01, 1'b1, 1'b0, 8'h20, 8'h00, 64'h0, 2'b10, 64'h0, DM};
        vt[13] = '{2'b11, 2'b00, 8'h20, 8'h10, 8'h00, 8'h00, 64'h0, 64'h0, 2'b00,  2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0, 2'b10, 64'h0, DM};
        vt[14] = '{2'b11, 2'b00, 8'h20, 8'h10, 8'h00, 8'h00, 64'h0, 64'h0, 2'b00,  2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0, 2'b11, DM, DM};
        vt[15] = '{2'b11, 2'b00, 8'h20, 8'h10, 8'h00, 8'h00, 64'h0, 64'h0, 2'b10,  2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0, 2'b11, DM, DM};
        vt[16] = '{2'b11, 2'b00, 8'h20, 8'h10, 8'h00, 8'h00, 64'h0, 64'h0, 2'b01,  2'b10, 1'b1, 1'b0, 8'h10, 8'h00, 64'h0, 2'b01, DM, 64'h0};
        vt[17] = '{2'b01, 2'b00, 8'h20, 8'h00, 8'h00, 8'h00, 64'h0, 64'h0, 2'b11,  2'b01, 1'b1, 1'b0, 8'h20, 8'h00, 64'h0, 2'b00, 64'h0, 64'h0};
        vt[18] = idle(2'b00, 2'b10, 64'h0, D0);
        vt[19] = idle(2'b11, 2'b11, DM, D0);
        vt[20] = '{2'b10, 2'b10, 8'h00, 8'h30, 8'h00, 8'hFF, 64'h0, A5, 2'b00,  2'b10, 1'b1, 1'b1, 8'h30, 8'hFF, A5, 2'b00, 64'h0, 64'h0};
        // both requesters stream reads: grants 0,1,-,0,1,-
        vt[21] = '{2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 64'h0, 64'h0, 2'b11,  2'b01, 1'b1, 1'b0, 8'h10, 8'h00, 64'h0, 2'b00, 64'h0, 64'h0};
        vt[22] = '{2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 64'h0, 64'h0, 2'b11,  2'b10, 1'b1, 1'b0, 8'h20, 8'h00, 64'h0, 2'b00, 64'h0, 64'h0};
        vt[23] = '{2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 64'h0, 64'h0, 2'b11,  2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0, 2'b01, D0, 64'h0};
        vt[24] = '{2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 64'h0, 64'h0, 2'b11,  2'b01, 1'b1, 1'b0, 8'h10, 8'h00, 64'h0, 2'b10, 64'h0, DM};
        vt[25] = '{2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 64'h0, 64'h0, 2'b11,  2'b10, 1'b1, 1'b0, 8'h20, 8'h00, 64'h0, 2'b00, 64'h0, 64'h0};
        vt[26] = '{2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 64'h0, 64'h0, 2'b11,  2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0, 2'b01, D0, 64'h0};
        vt[27] = idle(2'b11, 2'b10, 64'h0, DM);
        vt[28] = idle(2'b00, 2'b00, 64'h0, 64'h0);

        // Reset with requests pending: nothing may be granted or driven.
        rstb = 1'b0;
        tmp = idle(2'b00, 2'b00, 64'h0, 64'h0);
        tmp.valid = 2'b11;
        drive(tmp);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 64'(bus.req_ready), 64'd0);
        check("reset sram_ce", 64'(sram_ce), 64'd0);
        check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset init_done", 64'(init_done), 64'd0);
        @(posedge clk);
        #1;
        drive(idle(2'b00, 2'b00, 64'h0, 64'h0));
        rstb = 1'b1;
        #1;
        wait_init("first");

        for (int i = 0; i < NV; i++) begin
            drive(vt[i]);
            @(negedge clk);
            compare(i, vt[i]);
            @(posedge clk);
            #1;
        end

        // Read granted, then reset in the following cycle: the read must vanish.
        tmp = idle(2'b00, 2'b00, 64'h0, 64'h0);
        tmp.valid = 2'b01;
        tmp.a0 = 8'h20;
        drive(tmp);
        @(negedge clk);
        check("pre-reset grant", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        rstb = 1'b0;
        #1;
        check("mid reset req_ready", 64'(bus.req_ready), 64'd0);
        check("mid reset sram_ce", 64'(sram_ce), 64'd0);
        check("mid reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        drive(idle(2'b00, 2'b00, 64'h0, 64'h0));
        rstb = 1'b1;
        #1;
        wait_init("second");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("post-reset rsp_valid c%0d", k), 64'(bus.rsp_valid), 64'd0);
            @(posedge clk);
            #1;
        end

        tmp = idle(2'b00, 2'b00, 64'h0, 64'h0);
        tmp.valid = 2'b01;
        tmp.a0 = RST_ADDR;
        drive(tmp);
        @(negedge clk);
        check("post-reset grant", 64'(bus.req_ready), 64'd1);
        check("post-reset sram_addr", 64'(sram_addr), 64'(RST_ADDR));
        @(posedge clk);
        #1;
        drive(idle(2'b00, 2'b00, 64'h0, 64'h0));
        @(negedge clk);
        check("post-reset rsp_valid N+1", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post-reset rsp_valid N+2", 64'(bus.rsp_valid), 64'd1);
        check("post-reset rsp_rdata0", bus.rsp_rdata[63:0], RST_DATA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
